alu_op_issue: RTL and testbench
===============================

# alu_op_issue

Upstream issue stage for the 5-bit ALU: accepts operations (two operands plus a select code) over a valid/ready handshake and buffers them in a small FIFO. It presents them one per cycle on registered ALU inputs, captures the ALU's combinational 8-bit result into an output register and hands it downstream over a second valid/ready handshake. It also supports chained operations, where operand A is taken from the previous result, so multi-step computations run without host round-trips.

## Interface
- DEPTH, 4, FIFO entries; power of two, at least 2
- OPW, 5, operand width, matching ALU A/B
- SELW, 5, select width, matching ALU select
- RESW, 8, ALU result width
- clk  in  1  clock; all state updates on the rising edge
- rst  in  1  reset, asynchronous, active-high
- in_valid  in  1  operation offered
- in_ready  out  1  FIFO can accept this cycle
- in_a  in  OPW  operand A; ignored when in_chain=1
- in_b  in  OPW  operand B
- in_sel  in  SELW  ALU select code
- in_chain  in  1  use last_res[OPW-1:0] as operand A
- alu_a  out  OPW  registered operand A to ALU
- alu_b  out  OPW  registered operand B to ALU
- alu_sel  out  SELW  registered select to ALU
- alu_valid  out  1  issue register holds a live op
- alu_out  in  RESW  ALU result for current alu_a/alu_b/alu_sel, combinational
- res_valid  out  1  result register full
- res_ready  in  1  downstream accepts the result
- res_data  out  RESW  captured result
- count  out  $clog2(DEPTH+1)  FIFO occupancy, excluding the issue register
- div0_err  out  1  sticky divide-by-zero trap flag

## Operation
- Push: in_valid && in_ready writes {in_a, in_b, in_sel, in_chain} at the write pointer.
- in_ready = (count < DEPTH). There is no same-cycle pass-through when the FIFO is full.
- Pointers wrap modulo DEPTH.
- Simultaneous push and pop leaves count unchanged.
- res_fire = res_valid && res_ready.
- issue_fire = alu_valid && (!res_valid || res_ready).
- On issue_fire:
  - res_data <= alu_out.
  - res_valid <= 1.
  - last_res <= alu_out.
- If res_fire occurs without issue_fire, res_valid <= 0.
- Issue load condition, all of the following:
  - FIFO is non-empty.
  - The issue register is free (!alu_valid || issue_fire).
  - If the head entry has chain=1, alu_valid must be 0 in the current cycle.
- Effect of an issue load:
  - The head is popped and alu_valid <= 1.
  - alu_a <= chain ? last_res[OPW-1:0] : a; alu_b <= b; alu_sel <= sel.
- If the issue register frees without a load, alu_valid <= 0.
- Chained ops therefore always see the result of the immediately preceding op. The truncation to OPW bits is intentional.
- Reset mid-operation discards the FIFO contents, the issue register and the result register. No partial result is emitted.

## Timing
Reset values:
- in_ready=1, count=0.
- alu_valid=0, alu_a=0, alu_b=0, alu_sel=0.
- res_valid=0, res_data=0, last_res=0.
- div0_err=0.

Latency and throughput:
- Push accepted at edge N: alu_valid rises after edge N+1 and res_valid rises after edge N+2, so latency is 2 cycles with an empty pipeline.
- Throughput is 1 op/cycle for unchained ops when res_ready=1.
- Each chained op inserts exactly one bubble: alu_valid is low for one cycle before it.
- With res_ready held low, the pipeline holds 1 result + 1 issued op + DEPTH queued ops, and then in_ready drops.
- Outputs alu_a, alu_b and alu_sel are stable whenever alu_valid=1 and issue_fire=0.
- res_data is stable whenever res_valid=1 and res_ready=0.

## Configuration
- ALU_ISSUE_DIV0_TRAP_EN defined:
  - A head entry with sel==5'b00011 and b==0 is popped when it would otherwise load, but it is not issued.
  - It produces no result and does not update last_res.
  - div0_err is set to 1 and remains set until rst.
- ALU_ISSUE_DIV0_TRAP_EN undefined:
  - Such ops issue normally, and the result is whatever the ALU produces.
  - div0_err is tied to 0.

## Test plan
- Reset, then push (a=3, b=4, sel=0) with res_ready=1 -> alu_valid high after edge 1; res_valid=1 with res_data=7 after edge 2; count returns to 0.
- Hold res_ready=0 and push DEPTH+2 ops (DEPTH=4) -> in_ready drops after the 6th accept; count=4; release res_ready -> 6 results emerge in order, one per cycle.
- Push (5,3,sel=2), then chained (–,2,sel=0) -> results 15, then 17. Confirm the one-cycle bubble on alu_valid before the chained op.
- Push (31,1,sel=0) followed by chained (–,1,sel=0) -> results 32, then 1, because last_res[4:0]=0.
- With ALU_ISSUE_DIV0_TRAP_EN: push (9,0,sel=3), then (9,3,sel=3) -> only one result (3) appears, and div0_err=1 stays high until rst.
- Assert rst while 3 ops are queued and res_valid=1 -> all outputs return to their reset values immediately; no stale result appears after release.

Source files
------------

// File: rtl/alu_op_issue_if.sv
// Handshake and ALU-side signal bundle for alu_op_issue.
// The master side is the host/environment (it also plays the combinational ALU); the slave side is the issue stage.
interface alu_op_issue_if #(
  parameter int DEPTH = 4,
  parameter int OPW   = 5,
  parameter int SELW  = 5,
  parameter int RESW  = 8
);
  localparam int CW = $clog2(DEPTH + 1);

  logic            in_valid;
  logic            in_ready;
  logic [OPW-1:0]  in_a;
  logic [OPW-1:0]  in_b;
  logic [SELW-1:0] in_sel;
  logic            in_chain;
  logic [OPW-1:0]  alu_a;
  logic [OPW-1:0]  alu_b;
  logic [SELW-1:0] alu_sel;
  logic            alu_valid;
  logic [RESW-1:0] alu_out;
  logic            res_valid;
  logic            res_ready;
  logic [RESW-1:0] res_data;
  logic [CW-1:0]   count;
  logic            div0_err;

  modport master (
    output in_valid, in_a, in_b, in_sel, in_chain, res_ready, alu_out,
    input  in_ready, alu_a, alu_b, alu_sel, alu_valid, res_valid, res_data, count, div0_err
  );

  modport slave (
    input  in_valid, in_a, in_b, in_sel, in_chain, res_ready, alu_out,
    output in_ready, alu_a, alu_b, alu_sel, alu_valid, res_valid, res_data, count, div0_err
  );
endinterface

// File: rtl/alu_op_issue.sv
// Issue stage for the 5-bit ALU: op FIFO -> registered ALU inputs -> result register, with operand-A chaining.
// Optional ALU_ISSUE_DIV0_TRAP_EN: divide ops (sel 3) with b==0 are dropped and set the sticky div0_err flag.
module alu_op_issue #(
  parameter int DEPTH = 4,
  parameter int OPW   = 5,
  parameter int SELW  = 5,
  parameter int RESW  = 8
) (
  input logic           clk,
  input logic           rst,
  alu_op_issue_if.slave bus
);
  localparam int PW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW = $clog2(DEPTH + 1);

  typedef struct packed {
    logic [OPW-1:0]  a;
    logic [OPW-1:0]  b;
    logic [SELW-1:0] sel;
    logic            chain;
  } entry_t;

  entry_t          mem_q [DEPTH];
  entry_t          mem_d [DEPTH];
  logic [PW-1:0]   wr_ptr_q, wr_ptr_d;
  logic [PW-1:0]   rd_ptr_q, rd_ptr_d;
  logic [CW-1:0]   count_q, count_d;
  logic            alu_valid_q, alu_valid_d;
  logic [OPW-1:0]  alu_a_q, alu_a_d;
  logic [OPW-1:0]  alu_b_q, alu_b_d;
  logic [SELW-1:0] alu_sel_q, alu_sel_d;
  logic            res_valid_q, res_valid_d;
  logic [RESW-1:0] res_data_q, res_data_d;
  logic [RESW-1:0] last_res_q, last_res_d;
  logic            div0_err_q, div0_err_d;

  logic            in_ready_s;
  logic            push_s;
  logic            pop_s;
  logic            trap_s;
  logic            load_s;
  logic            res_fire_s;
  logic            issue_fire_s;
  logic            issue_free_s;
  entry_t          head_s;

  // Handshake qualifiers and the head-of-queue load decision.
  always_comb begin
    in_ready_s   = (count_q < CW'(DEPTH));
    push_s       = bus.in_valid && in_ready_s;
    head_s       = mem_q[rd_ptr_q];
    res_fire_s   = res_valid_q && bus.res_ready;
    issue_fire_s = alu_valid_q && (!res_valid_q || bus.res_ready);
    issue_free_s = !alu_valid_q || issue_fire_s;
    // A chained op waits until the issue register is empty, so last_res already holds its predecessor's result.
    pop_s        = (count_q != {CW{1'b0}}) && issue_free_s && (!head_s.chain || !alu_valid_q);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    trap_s       = pop_s && (head_s.sel == SELW'(3)) && (head_s.b == {OPW{1'b0}});
`else
    trap_s       = 1'b0;
`endif
    load_s       = pop_s && !trap_s;
  end

  // FIFO storage, pointers and occupancy.
  always_comb begin
    mem_d    = mem_q;
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    if (push_s) begin
      mem_d[wr_ptr_q] = '{a: bus.in_a, b: bus.in_b, sel: bus.in_sel, chain: bus.in_chain};
      wr_ptr_d        = wr_ptr_q + PW'(1);
    end else begin
      wr_ptr_d = wr_ptr_q;
    end
    if (pop_s) begin
      rd_ptr_d = rd_ptr_q + PW'(1);
    end else begin
      rd_ptr_d = rd_ptr_q;
    end
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
  end

  // Issue register, result register, chaining source and trap flag.
  always_comb begin
    alu_valid_d = alu_valid_q;
    alu_a_d     = alu_a_q;
    alu_b_d     = alu_b_q;
    alu_sel_d   = alu_sel_q;
    res_valid_d = res_valid_q;
    res_data_d  = res_data_q;
    last_res_d  = last_res_q;
    div0_err_d  = div0_err_q | trap_s;
    if (load_s) begin
      alu_valid_d = 1'b1;
      alu_a_d     = head_s.chain ? last_res_q[OPW-1:0] : head_s.a;
      alu_b_d     = head_s.b;
      alu_sel_d   = head_s.sel;
    end else if (issue_free_s) begin
      alu_valid_d = 1'b0;
    end else begin
      alu_valid_d = alu_valid_q;
    end
    if (issue_fire_s) begin
      res_valid_d = 1'b1;
      res_data_d  = bus.alu_out;
      last_res_d  = bus.alu_out;
    end else if (res_fire_s) begin
      res_valid_d = 1'b0;
    end else begin
      res_valid_d = res_valid_q;
    end
  end

  // State registers with asynchronous reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= '0;
      end
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      alu_valid_q <= 1'b0;
      alu_a_q     <= {OPW{1'b0}};
      alu_b_q     <= {OPW{1'b0}};
      alu_sel_q   <= {SELW{1'b0}};
      res_valid_q <= 1'b0;
      res_data_q  <= {RESW{1'b0}};
      last_res_q  <= {RESW{1'b0}};
      div0_err_q  <= 1'b0;
    end else begin
      mem_q       <= mem_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      alu_valid_q <= alu_valid_d;
      alu_a_q     <= alu_a_d;
      alu_b_q     <= alu_b_d;
      alu_sel_q   <= alu_sel_d;
      res_valid_q <= res_valid_d;
      res_data_q  <= res_data_d;
      last_res_q  <= last_res_d;
      div0_err_q  <= div0_err_d;
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.alu_valid = alu_valid_q;
  assign bus.alu_a     = alu_a_q;
  assign bus.alu_b     = alu_b_q;
  assign bus.alu_sel   = alu_sel_q;
  assign bus.res_valid = res_valid_q;
  assign bus.res_data  = res_data_q;
  assign bus.count     = count_q;
  assign bus.div0_err  = div0_err_q;
endmodule

// File: tb/tb_alu_op_issue.sv
// Directed self-checking bench for alu_op_issue; a small ALU stub (0 add, 1 sub, 2 mul, 3 div, else xor) drives alu_out.
module tb_alu_op_issue;
  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  alu_op_issue_if #(.DEPTH(4), .OPW(5), .SELW(5), .RESW(8)) bus ();

  alu_op_issue #(.DEPTH(4), .OPW(5), .SELW(5), .RESW(8)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Combinational ALU stub; divide by zero yields all ones.
  always_comb begin
    case (bus.alu_sel)
      5'd0:    bus.alu_out = 8'(bus.alu_a) + 8'(bus.alu_b);
      5'd1:    bus.alu_out = 8'(bus.alu_a) - 8'(bus.alu_b);
      5'd2:    bus.alu_out = 8'(bus.alu_a) * 8'(bus.alu_b);
      5'd3:    bus.alu_out = (bus.alu_b == 5'd0) ? 8'hFF : 8'(bus.alu_a) / 8'(bus.alu_b);
      default: bus.alu_out = 8'(bus.alu_a ^ bus.alu_b);
    endcase
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive(input logic v, input logic [4:0] a, input logic [4:0] b,
                       input logic [4:0] sel, input logic ch);
    bus.in_valid = v;
    bus.in_a     = a;
    bus.in_b     = b;
    bus.in_sel   = sel;
    bus.in_chain = ch;
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, ".in_ready"},  32'(bus.in_ready),  32'd1);
    chk({tag, ".count"},     32'(bus.count),     32'd0);
    chk({tag, ".alu_valid"}, 32'(bus.alu_valid), 32'd0);
    chk({tag, ".alu_a"},     32'(bus.alu_a),     32'd0);
    chk({tag, ".alu_b"},     32'(bus.alu_b),     32'd0);
    chk({tag, ".alu_sel"},   32'(bus.alu_sel),   32'd0);
    chk({tag, ".res_valid"}, 32'(bus.res_valid), 32'd0);
    chk({tag, ".res_data"},  32'(bus.res_data),  32'd0);
    chk({tag, ".div0_err"},  32'(bus.div0_err),  32'd0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    bus.res_ready = 1'b1;
    rst = 1'b1;
    step();
    step();
    chk_reset("por");
    rst = 1'b0;
    step();

    // Single op, empty pipeline: 2-cycle latency.
    drive(1'b1, 5'd3, 5'd4, 5'd0, 1'b0);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("single.count1", 32'(bus.count), 32'd1);
    chk("single.alu_valid_lo", 32'(bus.alu_valid), 32'd0);
    step();
    chk("single.alu_valid", 32'(bus.alu_valid), 32'd1);
    chk("single.alu_a", 32'(bus.alu_a), 32'd3);
    chk("single.alu_b", 32'(bus.alu_b), 32'd4);
    chk("single.count0", 32'(bus.count), 32'd0);
    chk("single.res_valid_lo", 32'(bus.res_valid), 32'd0);
    step();
    chk("single.res_valid", 32'(bus.res_valid), 32'd1);
    chk("single.res_data", 32'(bus.res_data), 32'd7);
    chk("single.alu_idle", 32'(bus.alu_valid), 32'd0);
    step();
    chk("single.res_drain", 32'(bus.res_valid), 32'd0);

    // Backpressure: 1 result + 1 issued + 4 queued, then in_ready drops.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 6; i++) begin
      drive(1'b1, 5'(i + 1), 5'd1, 5'd0, 1'b0);
      chk($sformatf("bp.in_ready%0d", i), 32'(bus.in_ready), 32'd1);
      step();
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("bp.in_ready_full", 32'(bus.in_ready), 32'd0);
    chk("bp.count_full", 32'(bus.count), 32'd4);
    chk("bp.res_head", 32'(bus.res_data), 32'd2);
    chk("bp.alu_a_held", 32'(bus.alu_a), 32'd2);
    step();
    chk("bp.res_stable", 32'(bus.res_data), 32'd2);
    chk("bp.alu_stable", 32'(bus.alu_a), 32'd2);
    chk("bp.count_stable", 32'(bus.count), 32'd4);
    bus.res_ready = 1'b1;
    for (int k = 0; k < 6; k++) begin
      chk($sformatf("bp.out_valid%0d", k), 32'(bus.res_valid), 32'd1);
      chk($sformatf("bp.out_data%0d", k), 32'(bus.res_data), 32'(k + 2));
      step();
    end
    chk("bp.drained_valid", 32'(bus.res_valid), 32'd0);
    chk("bp.drained_count", 32'(bus.count), 32'd0);

    // Chain: 5*3=15, then 15+2=17 with one bubble.
    drive(1'b1, 5'd5, 5'd3, 5'd2, 1'b0);
    step();
    drive(1'b1, 5'd9, 5'd2, 5'd0, 1'b1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("chain.first_issue", 32'(bus.alu_a), 32'd5);
    step();
    chk("chain.res1", 32'(bus.res_data), 32'd15);
    chk("chain.bubble", 32'(bus.alu_valid), 32'd0);
    step();
    chk("chain.alu_valid", 32'(bus.alu_valid), 32'd1);
    chk("chain.alu_a", 32'(bus.alu_a), 32'd15);
    step();
    chk("chain.res2_valid", 32'(bus.res_valid), 32'd1);
    chk("chain.res2", 32'(bus.res_data), 32'd17);
    step();

    // Chain truncation: 31+1=32, last_res[4:0]=0 so next is 0+1=1.
    drive(1'b1, 5'd31, 5'd1, 5'd0, 1'b0);
    step();
    drive(1'b1, 5'd7, 5'd1, 5'd0, 1'b1);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    step();
    chk("trunc.res1", 32'(bus.res_data), 32'd32);
    step();
    chk("trunc.alu_a", 32'(bus.alu_a), 32'd0);
    step();
    chk("trunc.res2", 32'(bus.res_data), 32'd1);
    step();

    // Divide by zero followed by a valid divide.
    drive(1'b1, 5'd9, 5'd0, 5'd3, 1'b0);
    step();
    drive(1'b1, 5'd9, 5'd3, 5'd3, 1'b0);
    step();
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
`ifdef ALU_ISSUE_DIV0_TRAP_EN
    chk("div0.err_set", 32'(bus.div0_err), 32'd1);
    chk("div0.not_issued", 32'(bus.alu_valid), 32'd0);
    step();
    chk("div0.no_result", 32'(bus.res_valid), 32'd0);
    step();
    chk("div0.res_valid", 32'(bus.res_valid), 32'd1);
    chk("div0.res", 32'(bus.res_data), 32'd3);
    step();
    chk("div0.only_one", 32'(bus.res_valid), 32'd0);
    chk("div0.err_sticky", 32'(bus.div0_err), 32'd1);
`else
    chk("div0.issued", 32'(bus.alu_valid), 32'd1);
    step();
    chk("div0.res_alu", 32'(bus.res_data), 32'd255);
    step();
    chk("div0.res", 32'(bus.res_data), 32'd3);
    chk("div0.err_tied", 32'(bus.div0_err), 32'd0);
    step();
`endif

    // Reset mid-operation with 3 queued and a held result.
    bus.res_ready = 1'b0;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 5'(i + 10), 5'd2, 5'd0, 1'b0);
      step();
    end
    drive(1'b0, 5'd0, 5'd0, 5'd0, 1'b0);
    chk("mid.count", 32'(bus.count), 32'd3);
    chk("mid.res_valid", 32'(bus.res_valid), 32'd1);
    chk("mid.alu_valid", 32'(bus.alu_valid), 32'd1);
    rst = 1'b1;
    #1;
    chk_reset("mid_rst");
    step();
    rst = 1'b0;
    bus.res_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      chk($sformatf("post.res_valid%0d", i), 32'(bus.res_valid), 32'd0);
      chk($sformatf("post.alu_valid%0d", i), 32'(bus.alu_valid), 32'd0);
      chk($sformatf("post.count%0d", i), 32'(bus.count), 32'd0);
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
